// File: rtl/cs411_pkg.sv
// cs411_pkg: shared scratchpad map, status codes, controller state set and
// the default systolic tile edge.
package cs411_pkg;

   localparam int TILE_SIZE = 8;

   localparam logic [31:0] ADDR_START  = 32'd0;
   localparam logic [31:0] ADDR_MODE   = 32'd4;
   localparam logic [31:0] ADDR_M      = 32'd8;
   localparam logic [31:0] ADDR_K      = 32'd12;
   localparam logic [31:0] ADDR_N      = 32'd16;
   localparam logic [31:0] ADDR_STATUS = 32'd100;

   localparam logic [31:0] STAT_IDLE = 32'd0;
   localparam logic [31:0] STAT_DONE = 32'd1;
   localparam logic [31:0] STAT_ERR  = 32'd2;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CHECK,
      ST_ISSUE,
      ST_WAIT,
      ST_ADVANCE,
      ST_FINISH,
      ST_WAIT_CLR,
      ST_CLR,
      ST_ERR
   } state_t;

   // A dimension is usable when it is non-zero, a whole number of tiles and
   // within the array's supported range; tile must be a power of two.
   function automatic logic dim_valid(input logic [31:0] dim,
                                      input int unsigned tile,
                                      input int unsigned max_dim);
      return (dim != 32'd0) && ((dim & (tile - 1)) == 32'd0) && (dim <= max_dim);
   endfunction

endpackage

// File: rtl/cs411_tile_counter.sv
// cs411_tile_counter: nested (m, n, k) tile index walker, k innermost and
// m outermost, each wrapping to zero at its tile count.
module cs411_tile_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       step,
   input  logic [7:0] mt,
   input  logic [7:0] nt,
   input  logic [7:0] kt,
   output logic [7:0] m,
   output logic [7:0] n,
   output logic [7:0] k,
   output logic       last_k,
   output logic       last_all
);

   logic last_m;
   logic last_n;

   assign last_m   = (m == mt - 8'd1);
   assign last_n   = (n == nt - 8'd1);
   assign last_k   = (k == kt - 8'd1);
   assign last_all = last_m & last_n & last_k;

   // Advance the innermost index, carrying into n and then m on wrap.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         m <= 8'd0;
         n <= 8'd0;
         k <= 8'd0;
      end else if (step) begin
         if (!last_k) begin
            k <= k + 8'd1;
         end else begin
            k <= 8'd0;
            if (!last_n) begin
               n <= n + 8'd1;
            end else begin
               n <= 8'd0;
               m <= last_m ? 8'd0 : m + 8'd1;
            end
         end
      end
   end

endmodule

// File: rtl/cs411_sp_controller.sv
// cs411_sp_controller: polls the scratchpad for a start command, loads the
// GEMM shape, sequences array tiles and reports completion status.
module cs411_sp_controller
   import cs411_pkg::*;
#(
   parameter int TILE    = TILE_SIZE,
   parameter int MAX_DIM = 64
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] sp_addr,
   input  logic [31:0] sp_rdata,
   output logic [31:0] sp_wdata,
   output logic [3:0]  sp_web,
   output logic        mode,
   output logic [7:0]  tile_m,
   output logic [7:0]  tile_n,
   output logic [7:0]  tile_k,
   output logic        tile_first_k,
   output logic        tile_last_k,
   output logic        tile_start,
   input  logic        tile_done,
   output logic        busy
);

   localparam int SH = $clog2(TILE);

   state_t      state;
   logic [2:0]  load_cnt;
   logic        rd0_vld;
   logic [31:0] dim_m;
   logic [31:0] dim_k;
   logic [31:0] dim_n;
   logic [7:0]  mt;
   logic [7:0]  kt;
   logic [7:0]  nt;
   logic        dims_ok;
   logic        cnt_clr;
   logic        cnt_step;
   logic        last_all;

   assign mt = 8'(dim_m >> SH);
   assign kt = 8'(dim_k >> SH);
   assign nt = 8'(dim_n >> SH);

   assign dims_ok = dim_valid(dim_m, TILE, MAX_DIM) &&
                    dim_valid(dim_k, TILE, MAX_DIM) &&
                    dim_valid(dim_n, TILE, MAX_DIM);

   // Indices restart for every run and only move once per completed tile.
   assign cnt_clr  = (state == ST_CHECK);
   assign cnt_step = (state == ST_ADVANCE) && !last_all;

   assign tile_first_k = (tile_k == 8'd0);

   cs411_tile_counter u_tile_counter (
      .clk      (clk),
      .reset    (reset),
      .clr      (cnt_clr),
      .step     (cnt_step),
      .mt       (mt),
      .nt       (nt),
      .kt       (kt),
      .m        (tile_m),
      .n        (tile_n),
      .k        (tile_k),
      .last_k   (tile_last_k),
      .last_all (last_all)
   );

   // Control FSM; every SP port signal is registered and defaults to a read
   // of the start word so polling states need no explicit address setup.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         sp_addr    <= 32'd0;
         sp_wdata   <= 32'd0;
         sp_web     <= 4'b0000;
         mode       <= 1'b0;
         tile_start <= 1'b0;
         busy       <= 1'b0;
         load_cnt   <= 3'd0;
         rd0_vld    <= 1'b0;
         dim_m      <= 32'd0;
         dim_k      <= 32'd0;
         dim_n      <= 32'd0;
      end else begin
         // Read data is only trusted as the start word when the previous
         // cycle actually read address 0 (not a status write or shape read).
         rd0_vld    <= (sp_addr == ADDR_START) && (sp_web == 4'b0000);
         tile_start <= 1'b0;
         sp_addr    <= ADDR_START;
         sp_wdata   <= 32'd0;
         sp_web     <= 4'b0000;
         case (state)
            ST_IDLE: begin
               if (rd0_vld && (sp_rdata == 32'd1)) begin
                  state    <= ST_LOAD;
                  sp_addr  <= ADDR_MODE;
                  load_cnt <= 3'd0;
                  busy     <= 1'b1;
               end
            end
            ST_LOAD: begin
               load_cnt <= load_cnt + 3'd1;
               case (load_cnt)
                  3'd0: sp_addr <= ADDR_M;
                  3'd1: begin
                     mode    <= sp_rdata[0];
                     sp_addr <= ADDR_K;
                  end
                  3'd2: begin
                     dim_m   <= sp_rdata;
                     sp_addr <= ADDR_N;
                  end
                  3'd3: dim_k <= sp_rdata;
                  default: begin
                     dim_n <= sp_rdata;
                     state <= ST_CHECK;
                  end
               endcase
            end
            ST_CHECK: begin
               if (dims_ok) begin
                  state      <= ST_ISSUE;
                  tile_start <= 1'b1;
               end else begin
                  state    <= ST_ERR;
                  sp_addr  <= ADDR_STATUS;
                  sp_wdata <= STAT_ERR;
                  sp_web   <= 4'b1111;
               end
            end
            ST_ISSUE: state <= ST_WAIT;
            ST_WAIT: begin
               if (tile_done) state <= ST_ADVANCE;
            end
            ST_ADVANCE: begin
               if (last_all) begin
                  state    <= ST_FINISH;
                  sp_addr  <= ADDR_STATUS;
                  sp_wdata <= STAT_DONE;
                  sp_web   <= 4'b1111;
               end else begin
                  state      <= ST_ISSUE;
                  tile_start <= 1'b1;
               end
            end
            ST_FINISH: state <= ST_WAIT_CLR;
            ST_ERR:    state <= ST_WAIT_CLR;
            ST_WAIT_CLR: begin
               if (rd0_vld && (sp_rdata == 32'd0)) begin
                  state    <= ST_CLR;
                  sp_addr  <= ADDR_STATUS;
                  sp_wdata <= STAT_IDLE;
                  sp_web   <= 4'b1111;
               end
            end
            ST_CLR: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cs411_sp_controller.sv
// tb_cs411_sp_controller: scratchpad + array model around the controller,
// with directed and randomized GEMM shapes checked against a loop model.
module tb_cs411_sp_controller;

   logic        clk;
   logic        reset;
   logic [31:0] sp_addr;
   logic [31:0] sp_rdata;
   logic [31:0] sp_wdata;
   logic [3:0]  sp_web;
   logic        mode;
   logic [7:0]  tile_m;
   logic [7:0]  tile_n;
   logic [7:0]  tile_k;
   logic        tile_first_k;
   logic        tile_last_k;
   logic        tile_start;
   logic        tile_done;
   logic        busy;

   logic [31:0] mem [64] = '{default: '0};
   logic        host_we = 1'b0;
   logic [31:0] host_addr = 32'd0;
   logic [31:0] host_data = 32'd0;
   int          cyc = 0;

   bit dbl_en = 0;
   bit coinc_en = 0;
   bit spur_en = 0;
   int done_cnt = 0;
   bit dbl_pend = 0;

   logic [31:0] obs_tiles[$];
   int          obs_cyc[$];
   logic [31:0] obs_writes[$];
   int          bad_wr = 0;
   int          bad_pulse = 0;
   logic        prev_ts = 1'b0;

   int n_cmp = 0;
   int n_mis = 0;

   cs411_sp_controller #(.TILE(8), .MAX_DIM(64)) dut (
      .clk          (clk),
      .reset        (reset),
      .sp_addr      (sp_addr),
      .sp_rdata     (sp_rdata),
      .sp_wdata     (sp_wdata),
      .sp_web       (sp_web),
      .mode         (mode),
      .tile_m       (tile_m),
      .tile_n       (tile_n),
      .tile_k       (tile_k),
      .tile_first_k (tile_first_k),
      .tile_last_k  (tile_last_k),
      .tile_start   (tile_start),
      .tile_done    (tile_done),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, got no summary, required completion");
      $fatal(1, "watchdog expired");
   end

   // Scratchpad BRAM, read-first, one-cycle read latency; host has its own port.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (host_we) mem[host_addr[7:2]] <= host_data;
      if (sp_web == 4'hF) mem[sp_addr[7:2]] <= sp_wdata;
      sp_rdata <= mem[sp_addr[7:2]];
   end

   // Array model: tile_done 20 cycles after each tile_start, plus optional noise.
   always @(negedge clk) begin
      tile_done = 1'b0;
      if (reset) begin
         done_cnt = 0;
         dbl_pend = 0;
      end else begin
         if (dbl_pend) begin
            tile_done = 1'b1;
            dbl_pend = 0;
         end
         if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) begin
               tile_done = 1'b1;
               dbl_pend = dbl_en;
            end
         end
         if (tile_start) begin
            done_cnt = 20;
            if (coinc_en) tile_done = 1'b1;
         end
         if (spur_en && !busy && (cyc % 7 == 0)) tile_done = 1'b1;
      end
   end

   function automatic logic [31:0] tup(input logic md, input logic fk, input logic lk,
                                       input logic [7:0] m, input logic [7:0] n,
                                       input logic [7:0] k);
      return {5'd0, md, fk, lk, m, n, k};
   endfunction

   // Observation log of launched tiles and SP writes.
   always @(negedge clk) begin
      if (tile_start) begin
         obs_tiles.push_back(tup(mode, tile_first_k, tile_last_k, tile_m, tile_n, tile_k));
         obs_cyc.push_back(cyc);
      end
      if (tile_start && prev_ts) bad_pulse++;
      prev_ts = tile_start;
      if (sp_web != 4'h0) obs_writes.push_back({sp_addr[15:0], sp_wdata[15:0]});
      if (sp_web != 4'h0 && sp_web != 4'hF) bad_wr++;
      if (sp_web == 4'h0 && sp_wdata != 32'd0) bad_wr++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, required %0h", tag, obs, exp);
      end
   endtask

   task automatic host_wr(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      host_we = 1'b1;
      host_addr = addr;
      host_data = data;
      @(negedge clk);
      host_we = 1'b0;
   endtask

   function automatic bit dim_ok(input int d);
      return (d > 0) && (d % 8 == 0) && (d <= 64);
   endfunction

   function automatic int pick_dim();
      int r;
      r = $urandom_range(0, 13);
      case (r)
         0: return 0;
         1: return 8 * $urandom_range(0, 3) + $urandom_range(1, 7);
         2: return 72;
         default: return 8 * $urandom_range(1, 4);
      endcase
   endfunction

   task automatic run_job(input logic md, input int dm, input int dk, input int dn,
                          input int hold);
      int tb0;
      int wb0;
      int c0;
      int exp_st;
      bit ok;
      bit valid;
      logic [31:0] exp_q[$];
      tb0 = obs_tiles.size();
      wb0 = obs_writes.size();
      host_wr(32'd4, {31'd0, md});
      host_wr(32'd8, dm);
      host_wr(32'd12, dk);
      host_wr(32'd16, dn);
      host_wr(32'd0, 32'd1);
      c0 = cyc;
      valid = dim_ok(dm) && dim_ok(dk) && dim_ok(dn);
      exp_st = valid ? 1 : 2;
      if (valid)
         for (int m = 0; m < dm / 8; m++)
            for (int n = 0; n < dn / 8; n++)
               for (int k = 0; k < dk / 8; k++)
                  exp_q.push_back(tup(md, k == 0, k == dk / 8 - 1, 8'(m), 8'(n), 8'(k)));
      ok = 0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (mem[25] != 32'd0) begin
            ok = 1;
            break;
         end
      end
      check("finish_seen", {31'd0, ok}, 32'd1);
      check("status", mem[25], exp_st);
      check("busy_wait_clr", {31'd0, busy}, 32'd1);
      check("tile_count", obs_tiles.size() - tb0, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (tb0 + i < obs_tiles.size())
            check($sformatf("tile%0d", i), obs_tiles[tb0 + i], exp_q[i]);
      if (valid && obs_cyc.size() > tb0)
         check("start_latency", obs_cyc[tb0] - c0, 32'd8);
      check("fin_write_count", obs_writes.size() - wb0, 32'd1);
      if (obs_writes.size() > wb0)
         check("fin_write", obs_writes[wb0], {16'd100, 16'(exp_st)});
      repeat (hold) @(negedge clk);
      check("hold_status", mem[25], exp_st);
      check("hold_busy", {31'd0, busy}, 32'd1);
      check("hold_tiles", obs_tiles.size() - tb0, exp_q.size());
      host_wr(32'd0, 32'd0);
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (mem[25] == 32'd0 && !busy) begin
            ok = 1;
            break;
         end
      end
      check("clear_seen", {31'd0, ok}, 32'd1);
      check("clr_write_count", obs_writes.size() - wb0, 32'd2);
      if (obs_writes.size() > wb0 + 1)
         check("clr_write", obs_writes[wb0 + 1], {16'd100, 16'd0});
   endtask

   task automatic reset_mid_run();
      int tb0;
      int wb0;
      bit ok;
      tb0 = obs_tiles.size();
      wb0 = obs_writes.size();
      host_wr(32'd4, 32'd1);
      host_wr(32'd8, 32'd16);
      host_wr(32'd12, 32'd16);
      host_wr(32'd16, 32'd16);
      host_wr(32'd0, 32'd1);
      ok = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (obs_tiles.size() - tb0 >= 3) begin
            ok = 1;
            break;
         end
      end
      check("third_tile_seen", {31'd0, ok}, 32'd1);
      repeat (4) @(negedge clk);
      host_wr(32'd0, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_web", {28'd0, sp_web}, 32'd0);
      check("rst_addr", sp_addr, 32'd0);
      check("rst_idx", {8'd0, tile_m, tile_n, tile_k}, 32'd0);
      check("rst_mode_ts", {30'd0, mode, tile_start}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      check("abort_writes", obs_writes.size() - wb0, 32'd0);
      check("abort_status", mem[25], 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_tiles", obs_tiles.size() - tb0, 32'd3);
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_sp", {sp_addr[15:0], sp_wdata[11:0], sp_web}, 32'd0);
      check("reset_outs", {22'd0, mode, tile_start, tile_m}, 32'd0);
      check("reset_nk", {16'd0, tile_n, tile_k}, 32'd0);
      reset = 1'b0;

      // Spurious tile_done while idle must never launch anything.
      spur_en = 1;
      repeat (40) @(negedge clk);
      spur_en = 0;
      check("idle_spur_tiles", obs_tiles.size(), 32'd0);
      check("idle_spur_busy", {31'd0, busy}, 32'd0);

      run_job(1'b1, 8, 8, 8, 5);
      run_job(1'b0, 16, 24, 8, 3);
      run_job(1'b0, 12, 8, 8, 4);
      run_job(1'b1, 8, 0, 8, 2);
      run_job(1'b0, 64, 8, 8, 2);
      run_job(1'b1, 8, 72, 8, 2);

      dbl_en = 1;
      coinc_en = 1;
      spur_en = 1;
      run_job(1'b0, 16, 8, 16, 3);
      dbl_en = 0;
      coinc_en = 0;
      spur_en = 0;

      reset_mid_run();
      run_job(1'b1, 16, 16, 16, 5);

      run_job(1'b1, 8, 16, 8, 200);

      for (int j = 0; j < 6; j++)
         run_job(1'($urandom_range(0, 1)), pick_dim(), pick_dim(), pick_dim(),
                 $urandom_range(0, 30));

      check("sp_write_form", bad_wr, 32'd0);
      check("tile_start_pulse", bad_pulse, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/cs411_sp_controller.md
CS411_SP_CONTROLLER -- requirements
Module: cs411_sp_controller

Interface
REQ-001 The block SHALL have parameter TILE, default 8, meaning the systolic array edge length in elements.
REQ-002 The block SHALL have parameter MAX_DIM, default 64, meaning the largest accepted M, K or N.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port sp_addr, output, 32, SP BRAM port-B byte address.
REQ-006 The block SHALL have port sp_rdata, input, 32, SP BRAM port-B read data, valid one cycle after sp_addr.
REQ-007 The block SHALL have port sp_wdata, output, 32, SP BRAM port-B write data.
REQ-008 The block SHALL have port sp_web, output, 4, SP BRAM byte write enables; 4'b1111 writes, 0 reads.
REQ-009 The block SHALL have port mode, output, 1, latched dataflow: 0 = WS, 1 = OS.
REQ-010 The block SHALL have ports tile_m, tile_n and tile_k, each output, 8, the current tile indices.
REQ-011 The block SHALL have port tile_first_k, output, 1, asserted when tile_k == 0 (the array clears its accumulators).
REQ-012 The block SHALL have port tile_last_k, output, 1, asserted when tile_k is the last K tile (the array writes O BRAM).
REQ-013 The block SHALL have port tile_start, output, 1, a one-cycle pulse that launches a tile.
REQ-014 The block SHALL have port tile_done, input, 1, a one-cycle pulse from the array when the tile completes.
REQ-015 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-016 SP map (byte addresses) SHALL be: 0 start, 4 mode, 8 M, 12 K, 16 N, 100 status; status values 0 idle, 1 done, 2 error.
REQ-017 FSM states SHALL be IDLE, LOAD, CHECK, ISSUE, WAIT, ADVANCE, FINISH, WAIT_CLR, CLR, ERR.
REQ-018 In IDLE the block SHALL read address 0 every cycle; sp_rdata == 1 moves it to LOAD, and any other value keeps it in IDLE.
REQ-019 In LOAD the block SHALL issue reads of 4, 8, 12 and 16 on consecutive cycles and capture each result one cycle later; LOAD takes 5 cycles.
REQ-020 In CHECK, if M, K or N is 0, not a multiple of TILE, or greater than MAX_DIM, the block SHALL go to ERR; otherwise it SHALL go to ISSUE with all tile indices 0.
REQ-021 Tile counts SHALL be Mt = M/TILE, Kt = K/TILE and Nt = N/TILE; the division is a shift, and TILE is a power of two.
REQ-022 In ISSUE the block SHALL pulse tile_start for one cycle and then go to WAIT.
REQ-023 In WAIT the block SHALL hold the tile indices stable until tile_done, then go to ADVANCE.
REQ-024 ADVANCE SHALL step tile_k innermost, then tile_n, then tile_m outermost, wrapping each to 0; after the last (m, n, k) it goes to FINISH, otherwise to ISSUE.
REQ-025 FINISH SHALL write 1 to address 100 for one cycle.
REQ-026 WAIT_CLR SHALL read address 0 every cycle until sp_rdata == 0, then go to CLR.
REQ-027 CLR SHALL write 0 to address 100 for one cycle and then go to IDLE.
REQ-028 ERR SHALL write 2 to address 100 for one cycle and then go to WAIT_CLR.
REQ-029 Except in the FINISH, CLR and ERR write cycles, sp_web SHALL be 0 and sp_wdata SHALL be 0.
REQ-030 tile_done SHALL be ignored outside WAIT, and a tile_done coincident with tile_start SHALL be ignored.
REQ-031 Writes to address 0 during a run SHALL have no effect until WAIT_CLR.
REQ-032 The start-to-first-tile_start latency SHALL be 8 cycles: 1 cycle IDLE detect, 5 LOAD, 1 CHECK, then the pulse.

Reset
REQ-033 On reset the FSM SHALL enter IDLE with sp_addr, sp_wdata, sp_web, mode, tile indices, tile_start and busy all 0 and the latched M/K/N cleared.
REQ-034 Reset mid-run SHALL abort the run without writing SP; status stays at its last value.

Structure
REQ-035 A shared package cs411_pkg SHALL hold the SP address constants, status codes, the state enum and TILE.
REQ-036 One sub-module, cs411_tile_counter, SHALL implement the 3-level nested index counter with wrap and last flags.

Verification
REQ-037 Host writes mode 1, M=K=N=8, start=1; the model returns tile_done 20 cycles after each start → exactly 1 tile_start; first/last_k both 1; status reads 1; host clears 0 → status returns to 0.
REQ-038 mode 0, M=16, K=24, N=8 → 6 tile_starts in (m,n,k) order (0,0,0),(0,0,1),(0,0,2),(1,0,0),(1,0,1),(1,0,2); tile_last_k on k=2 only.
REQ-039 M=12 (not a multiple of 8) → no tile_start; status 2; after host writes 0 to start, status 0 and busy 0.
REQ-040 Spurious tile_done in IDLE and a second tile_done in WAIT → tile count unchanged, no extra advance.
REQ-041 Reset asserted in WAIT of tile 3 of M=K=N=16 → IDLE next cycle, busy 0, no SP write; a new start then runs all 8 tiles.
REQ-042 Host holds start=1 for 200 cycles after status 1 → the block stays in WAIT_CLR with no second run; status 0 only after start is cleared.
